// File: rtl/dmem_ctrl_if.sv
// Request/response and data-bus signals of the data-memory access controller.
// master = pipeline stage plus bus fabric; slave = dmem_ctrl.
interface dmem_ctrl_if;
    logic        REQ_VALID;
    logic        REQ_WE;
    logic [1:0]  REQ_SIZE;
    logic        REQ_UNSIGNED;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        STALL;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic [31:0] BUS_ADDR;
    logic [3:0]  BUS_STRB;
    logic [31:0] BUS_WDATA;
    logic        BUS_ACK;
    logic [31:0] BUS_RDATA;

    modport master (
        output REQ_VALID, REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA,
        output BUS_ACK, BUS_RDATA,
        input  STALL, RSP_VALID, RSP_RDATA, RSP_ERR,
        input  BUS_REQ, BUS_WE, BUS_ADDR, BUS_STRB, BUS_WDATA
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA,
        input  BUS_ACK, BUS_RDATA,
        output STALL, RSP_VALID, RSP_RDATA, RSP_ERR,
        output BUS_REQ, BUS_WE, BUS_ADDR, BUS_STRB, BUS_WDATA
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Single-beat load/store controller between the RV32I memory stage and the data bus.
// state | meaning
// IDLE  | waiting for a request; illegal requests go straight to RESP
// BUS   | bus transaction in flight, pipeline held
// RESP  | one-cycle completion pulse, no new request accepted
module dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic        CLK,
    input logic        RST,
    dmem_ctrl_if.slave dif
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        accept, finish_ok, finish_to;
    logic        illegal;
    logic [1:0]  off;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted, load_ext;

    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q, off_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  strb_q;
    logic [9:0]  cnt_q;

    always_comb begin
        off     = dif.REQ_ADDR[1:0];
        illegal = (dif.REQ_SIZE == 2'd3) ||
                  (dif.REQ_SIZE == 2'd1 && dif.REQ_ADDR[0]) ||
                  (dif.REQ_SIZE == 2'd2 && dif.REQ_ADDR[1:0] != 2'd0);
        strb_d  = 4'b1111;
        wdata_d = dif.REQ_WDATA;
        case (dif.REQ_SIZE)
            2'd0: begin
                strb_d  = 4'b0001 << off;
                wdata_d = {4{dif.REQ_WDATA[7:0]}};
            end
            2'd1: begin
                strb_d  = 4'b0011 << off;
                wdata_d = {2{dif.REQ_WDATA[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted  = dif.BUS_RDATA >> {off_q, 3'b000};
        load_ext = shifted;
        case (size_q)
            2'd0: load_ext = uns_q ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
            2'd1: load_ext = uns_q ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // ACK wins over a timeout that expires in the same cycle
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        case (state_q)
            IDLE: if (dif.REQ_VALID) begin
                accept  = 1'b1;
                state_d = illegal ? RESP : BUS;
            end
            BUS: if (dif.BUS_ACK) begin
                finish_ok = 1'b1;
                state_d   = RESP;
            end else if (cnt_q == TO_LAST) begin
                finish_to = 1'b1;
                state_d   = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            off_q   <= 2'd0;
            addr_q  <= 32'h0;
            strb_q  <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= 10'd0;
        end else begin
            if (accept) begin
                size_q <= dif.REQ_SIZE;
                uns_q  <= dif.REQ_UNSIGNED;
                off_q  <= off;
                cnt_q  <= 10'd0;
                if (illegal) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end else begin
                    we_q    <= dif.REQ_WE;
                    addr_q  <= {dif.REQ_ADDR[31:2], 2'b00};
                    strb_q  <= strb_d;
                    wdata_q <= wdata_d;
                end
            end
            if (state_q == BUS && cnt_q != 10'h3FF) cnt_q <= cnt_q + 10'd1;
            if (finish_ok) begin
                rdata_q <= we_q ? 32'h0 : load_ext;
                err_q   <= 1'b0;
            end
            if (finish_to) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b1;
            end
        end
    end

    // STALL is gated by reset so it reads 0 while reset is held, whatever REQ_VALID does
    assign dif.STALL     = RST & (((state_q == IDLE) & dif.REQ_VALID) | (state_q == BUS));
    assign dif.RSP_VALID = (state_q == RESP);
    assign dif.RSP_RDATA = rdata_q;
    assign dif.RSP_ERR   = err_q;
    assign dif.BUS_REQ   = (state_q == BUS);
    assign dif.BUS_WE    = we_q;
    assign dif.BUS_ADDR  = addr_q;
    assign dif.BUS_STRB  = strb_q;
    assign dif.BUS_WDATA = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: per-cycle timing checks per scenario plus
// a response scoreboard fed at request time and drained on RSP_VALID.
module tb_dmem_ctrl;

    localparam int TO = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;

    logic        lg_stall[16], lg_breq[16], lg_rspv[16], lg_we[16];
    logic [31:0] lg_addr[16], lg_wdata[16];
    logic [3:0]  lg_strb[16];

    dmem_ctrl_if dif ();

    dmem_ctrl #(.TIMEOUT(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .dif (dif.slave)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (dif.RSP_VALID) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected rdata=%h err=%b required=no response",
                         dif.RSP_RDATA, dif.RSP_ERR);
            end else begin
                mon_e = exp_q.pop_front();
                if ({dif.RSP_RDATA, dif.RSP_ERR} !== {mon_e.rdata, mon_e.err}) begin
                    errors++;
                    $display("FAIL rsp_data got rdata=%h err=%b required rdata=%h err=%b",
                             dif.RSP_RDATA, dif.RSP_ERR, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    function automatic logic [31:0] exp_load(logic [31:0] rd, logic [1:0] size, logic uns, int off);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[off*8 +: 8];
        h = rd[(off & 2)*8 +: 16];
        case (size)
            2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] exp_strb(logic [1:0] size, int off);
        logic [3:0] s;
        int nb;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (size == 2'd2) off = 0;
        for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + nb);
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(logic [1:0] size, logic [31:0] w);
        case (size)
            2'd0:    return {w[7:0], w[7:0], w[7:0], w[7:0]};
            2'd1:    return {w[15:0], w[15:0]};
            default: return w;
        endcase
    endfunction

    // Drives one request, ACKs in cycle ack_cyc (0 = never), logs outputs per cycle.
    task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_cyc, input logic [31:0] rdata, input int ncyc);
        rsp_t e;
        logic ill;
        ill = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        if (ill || (ack_cyc == 0) || (ack_cyc > TO)) e = '{rdata: 32'h0, err: 1'b1};
        else if (we) e = '{rdata: 32'h0, err: 1'b0};
        else e = '{rdata: exp_load(rdata, size, uns, int'(addr[1:0])), err: 1'b0};
        for (int i = 0; i < 16; i++) lg_rspv[i] = 1'b0;
        @(posedge CLK); #1;
        dif.REQ_WE = we; dif.REQ_SIZE = size; dif.REQ_UNSIGNED = uns;
        dif.REQ_ADDR = addr; dif.REQ_WDATA = wdata; dif.REQ_VALID = 1'b1;
        exp_q.push_back(e);
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin
                @(posedge CLK); #1;
                if (lg_rspv[c-1]) dif.REQ_VALID = 1'b0;
            end
            dif.BUS_ACK   = (ack_cyc > 0) && (c == ack_cyc);
            dif.BUS_RDATA = dif.BUS_ACK ? rdata : $urandom();
            @(negedge CLK);
            lg_stall[c] = dif.STALL;   lg_breq[c]  = dif.BUS_REQ;
            lg_rspv[c]  = dif.RSP_VALID; lg_we[c]  = dif.BUS_WE;
            lg_addr[c]  = dif.BUS_ADDR; lg_wdata[c] = dif.BUS_WDATA;
            lg_strb[c]  = dif.BUS_STRB;
        end
        dif.REQ_VALID = 1'b0;
        dif.BUS_ACK   = 1'b0;
    endtask

    task automatic test_reset;
        dif.REQ_VALID = 1'b1; dif.REQ_WE = 1'b1; dif.REQ_SIZE = 2'd2; dif.REQ_UNSIGNED = 1'b0;
        dif.REQ_ADDR = 32'h40; dif.REQ_WDATA = 32'hDEAD_BEEF; dif.BUS_ACK = 1'b1; dif.BUS_RDATA = 32'h1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({dif.STALL, dif.RSP_VALID, dif.RSP_RDATA, dif.RSP_ERR, dif.BUS_REQ, dif.BUS_WE,
             dif.BUS_ADDR, dif.BUS_STRB, dif.BUS_WDATA} !== '0) begin
            errors++;
            $display("FAIL reset_outputs stall=%b rspv=%b rdata=%h err=%b breq=%b we=%b addr=%h strb=%b wdata=%h required all 0",
                     dif.STALL, dif.RSP_VALID, dif.RSP_RDATA, dif.RSP_ERR, dif.BUS_REQ,
                     dif.BUS_WE, dif.BUS_ADDR, dif.BUS_STRB, dif.BUS_WDATA);
        end
        dif.REQ_VALID = 1'b0; dif.BUS_ACK = 1'b0;
        #2 RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({dif.STALL, dif.RSP_VALID, dif.BUS_REQ} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release stall=%b rspv=%b breq=%b required 000",
                     dif.STALL, dif.RSP_VALID, dif.BUS_REQ);
        end
    endtask

    task automatic test_load_byte_signed;
        run_access(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234, 5);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({lg_stall[c], lg_breq[c], lg_rspv[c]} !== {c <= 1, c == 1, c == 2}) begin
                errors++;
                $display("FAIL lb_timing cycle=%0d stall/breq/rspv=%b%b%b required %b%b%b",
                         c, lg_stall[c], lg_breq[c], lg_rspv[c], c <= 1, c == 1, c == 2);
            end
        end
        checks++;
        if (lg_addr[1] !== 32'h1000 || lg_strb[1] !== exp_strb(2'd0, 3) || lg_we[1] !== 1'b0) begin
            errors++;
            $display("FAIL lb_bus addr=%h strb=%b we=%b required addr=00001000 strb=1000 we=0",
                     lg_addr[1], lg_strb[1], lg_we[1]);
        end
    endtask

    task automatic test_load_half_unsigned;
        run_access(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 4, 32'h8001_0000, 7);
        for (int c = 0; c < 7; c++) begin
            checks++;
            if ({lg_stall[c], lg_breq[c], lg_rspv[c]} !== {c <= 4, c >= 1 && c <= 4, c == 5}) begin
                errors++;
                $display("FAIL lhu_timing cycle=%0d stall/breq/rspv=%b%b%b required %b%b%b",
                         c, lg_stall[c], lg_breq[c], lg_rspv[c], c <= 4, c >= 1 && c <= 4, c == 5);
            end
        end
        checks++;
        if (lg_strb[2] !== 4'b1100 || lg_addr[2] !== 32'h2000) begin
            errors++;
            $display("FAIL lhu_bus strb=%b addr=%h required strb=1100 addr=00002000", lg_strb[2], lg_addr[2]);
        end
    endtask

    task automatic test_store_byte;
        run_access(1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h1234_56AB, 1, 32'h5555_5555, 4);
        checks++;
        if (lg_we[1] !== 1'b1 || lg_strb[1] !== 4'b0010 || lg_wdata[1] !== 32'hABAB_ABAB ||
            lg_addr[1] !== 32'h10 || lg_rspv[2] !== 1'b1) begin
            errors++;
            $display("FAIL sb_bus we=%b strb=%b wdata=%h addr=%h rspv2=%b required 1 0010 abababab 00000010 1",
                     lg_we[1], lg_strb[1], lg_wdata[1], lg_addr[1], lg_rspv[2]);
        end
    endtask

    task automatic test_illegal;
        logic [1:0]  sz[3]  = '{2'd2, 2'd3, 2'd1};
        logic [31:0] ad[3]  = '{32'h6, 32'h0, 32'h101};
        for (int k = 0; k < 3; k++) begin
            run_access(k == 0, sz[k], 1'b0, ad[k], 32'hFFFF_FFFF, 1, 32'h1234_5678, 4);
            for (int c = 0; c < 4; c++) begin
                checks++;
                if ({lg_stall[c], lg_breq[c], lg_rspv[c]} !== {c == 0, 1'b0, c == 1}) begin
                    errors++;
                    $display("FAIL illegal_timing case=%0d cycle=%0d stall/breq/rspv=%b%b%b required %b0%b",
                             k, c, lg_stall[c], lg_breq[c], lg_rspv[c], c == 0, c == 1);
                end
            end
        end
    endtask

    task automatic test_timeout;
        run_access(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 7, 32'hCAFE_F00D, 9);
        for (int c = 0; c < 9; c++) begin
            checks++;
            if ({lg_stall[c], lg_breq[c], lg_rspv[c]} !== {c <= TO, c >= 1 && c <= TO, c == TO + 1}) begin
                errors++;
                $display("FAIL timeout_timing cycle=%0d stall/breq/rspv=%b%b%b required %b%b%b",
                         c, lg_stall[c], lg_breq[c], lg_rspv[c], c <= TO, c >= 1 && c <= TO, c == TO + 1);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r, addr, wd, rd;
        logic [1:0]  size;
        logic        we, uns;
        int          ack, off;
        for (int k = 0; k < 10; k++) begin
            size = 2'($urandom_range(0, 2));
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            r    = $urandom();
            off  = (size == 2'd0) ? int'($urandom_range(0, 3)) : (size == 2'd1) ? 2 * int'($urandom_range(0, 1)) : 0;
            addr = (r & 32'hFFFF_FFFC) | 32'(off);
            wd   = $urandom();
            rd   = $urandom();
            ack  = int'($urandom_range(1, 3));
            run_access(we, size, uns, addr, wd, ack, rd, ack + 2);
            checks++;
            if (lg_rspv[ack+1] !== 1'b1 || lg_breq[ack] !== 1'b1 || lg_breq[ack+1] !== 1'b0 ||
                lg_addr[1] !== (addr & 32'hFFFF_FFFC) || lg_strb[1] !== exp_strb(size, off) ||
                lg_we[1] !== we || (we && lg_wdata[1] !== exp_wdata(size, wd))) begin
                errors++;
                $display("FAIL b2b k=%0d rspv=%b addr=%h strb=%b we=%b wdata=%h required addr=%h strb=%b we=%b wdata=%h",
                         k, lg_rspv[ack+1], lg_addr[1], lg_strb[1], lg_we[1], lg_wdata[1],
                         addr & 32'hFFFF_FFFC, exp_strb(size, off), we, exp_wdata(size, wd));
            end
        end
    endtask

    task automatic test_reset_mid;
        @(posedge CLK); #1;
        dif.REQ_WE = 1'b0; dif.REQ_SIZE = 2'd2; dif.REQ_UNSIGNED = 1'b0;
        dif.REQ_ADDR = 32'h3000; dif.REQ_WDATA = 32'h0; dif.REQ_VALID = 1'b1; dif.BUS_ACK = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        checks++;
        if (dif.BUS_REQ !== 1'b1 || dif.BUS_ADDR !== 32'h3000) begin
            errors++;
            $display("FAIL rstmid_pending breq=%b addr=%h required 1 00003000", dif.BUS_REQ, dif.BUS_ADDR);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({dif.STALL, dif.RSP_VALID, dif.RSP_RDATA, dif.RSP_ERR, dif.BUS_REQ, dif.BUS_WE,
             dif.BUS_ADDR, dif.BUS_STRB, dif.BUS_WDATA} !== '0) begin
            errors++;
            $display("FAIL rstmid_async stall=%b rspv=%b rdata=%h err=%b breq=%b we=%b addr=%h strb=%b wdata=%h required all 0",
                     dif.STALL, dif.RSP_VALID, dif.RSP_RDATA, dif.RSP_ERR, dif.BUS_REQ,
                     dif.BUS_WE, dif.BUS_ADDR, dif.BUS_STRB, dif.BUS_WDATA);
        end
        dif.BUS_ACK = 1'b1; dif.BUS_RDATA = 32'h7777_7777;
        @(posedge CLK); #2;
        dif.REQ_VALID = 1'b0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({dif.RSP_VALID, dif.BUS_REQ, dif.STALL} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_late_ack rspv=%b breq=%b stall=%b required 000",
                     dif.RSP_VALID, dif.BUS_REQ, dif.STALL);
        end
        dif.BUS_ACK = 1'b0;
        run_access(1'b0, 2'd0, 1'b1, 32'h0000_3001, 32'h0, 2, 32'h1122_8844, 5);
        checks++;
        if (lg_rspv[3] !== 1'b1 || lg_rspv[1] !== 1'b0 || lg_rspv[2] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_recover rspv c1..c3=%b%b%b required 001", lg_rspv[1], lg_rspv[2], lg_rspv[3]);
        end
    endtask

    initial begin
        test_reset();
        test_load_byte_signed();
        test_load_half_unsigned();
        test_store_byte();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
